// File: rtl/pkt_rom_writer.sv
// Canned-packet source: streams a command-selected byte packet from an internal ROM into a TX FIFO.
// Define PKT_CSUM_EN to append a modulo-2^DW checksum byte after each payload.
module pkt_rom_writer #(
    parameter int DW        = 8,
    parameter int CMD_W     = 4,
    parameter int NUM_PKT   = 8,
    parameter int ROM_DEPTH = 256,
    parameter int LEN_W     = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             err,
    input  logic             fs,
    input  logic [CMD_W-1:0] cmd,
    output logic             fd,
    output logic             cmd_err,
    input  logic             fifo_full,
    output logic [DW-1:0]    fifo_txd,
    output logic             fifo_txen,
    output logic [2:0]       so,
    output logic [LEN_W-1:0] byte_cnt,
    output logic [15:0]      pkt_cnt
);

    localparam int AW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
    localparam logic [31:0] NUM_PKT_U = NUM_PKT;
    localparam logic [31:0] ROM_LAST  = ROM_DEPTH - 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SEND = 3'd2,
        CSUM = 3'd3,
        LAST = 3'd4
    } state_t;

`ifdef PKT_CSUM_EN
    localparam state_t AFTER_DATA = CSUM;
`else
    localparam state_t AFTER_DATA = LAST;
`endif

    // Packet table and ROM contents: base = 16*k, len = 8+k, rom[i] = i mod 2^DW.
    function automatic logic [AW-1:0] tab_base(input logic [CMD_W-1:0] k);
        return AW'((32'(k) * 32'd16) % 32'(ROM_DEPTH));
    endfunction

    function automatic logic [LEN_W-1:0] tab_len(input logic [CMD_W-1:0] k);
        return LEN_W'(32'(k) + 32'd8);
    endfunction

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return DW'(a);
    endfunction

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        return (32'(a) == ROM_LAST) ? '0 : a + AW'(1);
    endfunction

    state_t           state;
    state_t           state_n;
    logic [AW-1:0]    addr;
    logic [LEN_W-1:0] len_q;
    logic             cmd_bad;
    logic             wr_ok;
    logic             data_wr;
    logic             pkt_done;
`ifdef PKT_CSUM_EN
    logic [DW-1:0]    sum;
`endif

    assign cmd_bad = (32'(cmd) >= NUM_PKT_U);
    assign wr_ok   = !fifo_full && !err;
    assign so      = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // err overrides everything: no write, no fd, no cmd_err, back to IDLE.
    always_comb begin
        state_n   = state;
        fifo_txen = 1'b0;
        fifo_txd  = '0;
        fd        = 1'b0;
        cmd_err   = 1'b0;
        case (state)
            IDLE: begin
                if (fs) state_n = LOAD;
            end
            LOAD: begin
                if (cmd_bad) begin
                    cmd_err = 1'b1;
                    state_n = LAST;
                end else if (tab_len(cmd) == '0) begin
                    state_n = AFTER_DATA;
                end else begin
                    state_n = SEND;
                end
            end
            SEND: begin
                fifo_txen = wr_ok;
                if (wr_ok) begin
                    fifo_txd = rom_word(addr);
                    if (byte_cnt == len_q - LEN_W'(1)) state_n = AFTER_DATA;
                end
            end
`ifdef PKT_CSUM_EN
            CSUM: begin
                fifo_txen = wr_ok;
                if (wr_ok) begin
                    fifo_txd = sum;
                    state_n  = LAST;
                end
            end
`endif
            LAST: begin
                fd = 1'b1;
                if (!fs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (err) begin
            state_n   = IDLE;
            fifo_txen = 1'b0;
            fifo_txd  = '0;
            fd        = 1'b0;
            cmd_err   = 1'b0;
        end
    end

    assign data_wr  = (state == SEND) && fifo_txen;
    assign pkt_done = (state_n == LAST) && (state != LAST) && !(state == LOAD && cmd_bad);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr     <= '0;
            len_q    <= '0;
            byte_cnt <= '0;
`ifdef PKT_CSUM_EN
            sum      <= '0;
`endif
        end else if (state == LOAD) begin
            addr     <= tab_base(cmd);
            len_q    <= tab_len(cmd);
            byte_cnt <= '0;
`ifdef PKT_CSUM_EN
            sum      <= '0;
`endif
        end else if (data_wr) begin
            addr <= next_addr(addr);
            if (byte_cnt != len_q) byte_cnt <= byte_cnt + LEN_W'(1);
`ifdef PKT_CSUM_EN
            sum  <= sum + fifo_txd;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt <= '0;
        end else if (pkt_done) begin
            pkt_cnt <= pkt_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pkt_rom_writer.sv
// Self-checking bench for pkt_rom_writer: vector table of packet requests plus abort/reset sequences.
module tb_pkt_rom_writer;

    localparam int DW      = 8;
    localparam int CMD_W   = 4;
    localparam int NUM_PKT = 8;
    localparam int LEN_W   = 12;

    logic             clk;
    logic             rst_n;
    logic             err;
    logic             fs;
    logic [CMD_W-1:0] cmd;
    logic             fd;
    logic             cmd_err;
    logic             fifo_full;
    logic [DW-1:0]    fifo_txd;
    logic             fifo_txen;
    logic [2:0]       so;
    logic [LEN_W-1:0] byte_cnt;
    logic [15:0]      pkt_cnt;

    pkt_rom_writer #(
        .DW(DW), .CMD_W(CMD_W), .NUM_PKT(NUM_PKT), .ROM_DEPTH(256), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .err(err), .fs(fs), .cmd(cmd),
        .fd(fd), .cmd_err(cmd_err), .fifo_full(fifo_full),
        .fifo_txd(fifo_txd), .fifo_txen(fifo_txen), .so(so),
        .byte_cnt(byte_cnt), .pkt_cnt(pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] cmd;
        int         stall_at;
        int         stall_len;
    } vec_t;

    int         errors = 0;
    int         checks = 0;
    int         wr_count = 0;
    int         cmd_err_cnt = 0;
    int         exp_pkts = 0;
    logic [7:0] sb[$];
    vec_t       vecs[9];

`ifdef PKT_CSUM_EN
    localparam int CSUM_BYTES = 1;
`else
    localparam int CSUM_BYTES = 0;
`endif

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard side: every write pops one expected byte.
    always @(negedge clk) begin
        if (fifo_txen === 1'b1) begin
            wr_count++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write: got data 0x%0h, expected no write", fifo_txd);
            end else begin
                checkOutput("txd", 32'(fifo_txd), 32'(sb.pop_front()));
            end
        end else if (rst_n === 1'b1) begin
            checkOutput("txd_idle_zero", 32'(fifo_txd), 32'd0);
        end
        if (cmd_err === 1'b1) cmd_err_cnt++;
    end

    task automatic applyStimulus(input vec_t v);
        bit         bad = (int'(v.cmd) >= NUM_PKT);
        int         len = 8 + int'(v.cmd);
        int         base = 16 * int'(v.cmd);
        int         exp_edges;
        int         edges = 0;
        int         stalled = 0;
        logic [7:0] s = 8'h00;
        if (!bad) begin
            for (int i = 0; i < len; i++) begin
                sb.push_back(8'((base + i) % 256));
                s = s + 8'((base + i) % 256);
            end
            if (CSUM_BYTES == 1) sb.push_back(s);
        end
        exp_edges = bad ? 2 : len + 2 + CSUM_BYTES + v.stall_len;
        wr_count = 0;
        cmd_err_cnt = 0;
        @(posedge clk); #1;
        cmd = v.cmd;
        fs = 1'b1;
        while (fd !== 1'b1 && edges < 300) begin
            @(posedge clk); #1;
            edges++;
            if (edges >= 2 && stalled < v.stall_len && wr_count == v.stall_at) begin
                fifo_full = 1'b1;
                stalled++;
            end else begin
                fifo_full = 1'b0;
            end
        end
        fifo_full = 1'b0;
        checkOutput($sformatf("fd_latency_cmd%0d", v.cmd), edges, exp_edges);
        checkOutput("state_last", 32'(so), 32'd4);
        @(posedge clk); #1;
        checkOutput("fd_hold_while_fs", 32'(fd), 32'd1);
        fs = 1'b0;
        if (!bad) exp_pkts++;
        checkOutput($sformatf("byte_cnt_cmd%0d", v.cmd), 32'(byte_cnt), bad ? 32'd0 : 32'(len));
        checkOutput("pkt_cnt", 32'(pkt_cnt), 32'(exp_pkts));
        checkOutput("cmd_err_pulses", cmd_err_cnt, bad ? 32'd1 : 32'd0);
        @(posedge clk); #1;
        checkOutput("fd_drop", 32'(fd), 32'd0);
        checkOutput("state_idle", 32'(so), 32'd0);
        checkOutput("sb_drained", sb.size(), 32'd0);
        sb.delete();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int edges;
        vecs[0] = '{4'd2,  -1, 0};
        vecs[1] = '{4'd0,   4, 3};
        vecs[2] = '{4'd7,  -1, 0};
        vecs[3] = '{4'd9,  -1, 0};
        vecs[4] = '{4'd5,   0, 2};
        vecs[5] = '{4'd8,  -1, 0};
        vecs[6] = '{4'd15, -1, 0};
        vecs[7] = '{4'd3,   7, 1};
        vecs[8] = '{4'd6,  13, 2};

        rst_n = 1'b0; err = 1'b0; fs = 1'b0; cmd = '0; fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_txen", 32'(fifo_txen), 32'd0);
        checkOutput("reset_fd", 32'(fd), 32'd0);
        checkOutput("reset_so", 32'(so), 32'd0);
        checkOutput("reset_pkt_cnt", 32'(pkt_cnt), 32'd0);
        checkOutput("reset_byte_cnt", 32'(byte_cnt), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

        // Abort after three bytes of cmd=1.
        sb.push_back(8'h10); sb.push_back(8'h11); sb.push_back(8'h12);
        wr_count = 0; edges = 0;
        @(posedge clk); #1;
        cmd = 4'd1; fs = 1'b1;
        while (wr_count < 3 && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
        checkOutput("err_reach_3", wr_count, 32'd3);
        err = 1'b1; fs = 1'b0;
        #1;
        checkOutput("err_txen_gate", 32'(fifo_txen), 32'd0);
        checkOutput("err_fd", 32'(fd), 32'd0);
        @(posedge clk); #1;
        checkOutput("err_state_idle", 32'(so), 32'd0);
        err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("err_fd_never", 32'(fd), 32'd0);
        checkOutput("err_pkt_cnt", 32'(pkt_cnt), 32'(exp_pkts));
        checkOutput("err_sb_drained", sb.size(), 32'd0);
        sb.delete();

        // Reset mid-SEND, then a full clean packet.
        for (int i = 0; i < 11; i++) sb.push_back(8'(48 + i));
        wr_count = 0; edges = 0;
        @(posedge clk); #1;
        cmd = 4'd3; fs = 1'b1;
        while (wr_count < 2 && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
        rst_n = 1'b0;
        #1;
        checkOutput("rst_txen", 32'(fifo_txen), 32'd0);
        checkOutput("rst_fd", 32'(fd), 32'd0);
        checkOutput("rst_so", 32'(so), 32'd0);
        checkOutput("rst_byte_cnt", 32'(byte_cnt), 32'd0);
        checkOutput("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        sb.delete();
        exp_pkts = 0;
        fs = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus('{4'd3, -1, 0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
